if_id_stage: RTL and testbench

Fetch stage plus IF/ID pipeline register for the five-stage core. Holds the PC, drives the synchronous-read instruction ROM, and applies load-use stalls and EX-resolved redirects. It presents the instruction, PC, PC+4 and debug-valid flag to the ID stage, directly upstream of the ID/EX register. Wrong-path and bubble slots are marked by setting bit 31 of the PC+4 value, which ID/EX treats as a discarded instruction.

---
 rtl/mycpu_pkg.sv | 42 ++++
 rtl/if_id_stage_pc_gen.sv | 50 +++++
 rtl/if_id_stage.sv | 134 +++++++++++++
 tb/tb_if_id_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// ---------------------------------------------------------------------------
// mycpu_pkg
// Shared definitions for the five-stage core front end.
//   RESET_PC    : first fetch address after reset
//   BUBBLE_PC4  : pc4 value marking an empty/discarded slot (discard bit set)
//   BUBBLE_PC   : pc value carried alongside a bubble (BUBBLE_PC4 - 4)
//   NOP_INST    : instruction word carried by a bubble (addi x0,x0,0)
//   DISCARD_BIT : pc4 bit that ID/EX treats as "throw this slot away"
//   fetch_state_e : fetch FSM states (BOOT, RUN)
//   if_id_t     : contents of one IF/ID pipeline slot
// ---------------------------------------------------------------------------
package mycpu_pkg;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_PC4  = 32'hFFFF_FF00;
    localparam logic [31:0] BUBBLE_PC   = BUBBLE_PC4 - 32'd4;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam int          DISCARD_BIT = 31;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        have_inst;
    } if_id_t;

    // Slot contents used whenever the ID stage must see nothing useful.
    function automatic if_id_t bubble_slot();
        if_id_t slot;
        slot.inst      = NOP_INST;
        slot.pc        = BUBBLE_PC;
        slot.pc4       = BUBBLE_PC4;
        slot.have_inst = 1'b0;
        return slot;
    endfunction

endpackage

// File: rtl/if_id_stage_pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Program counter register and next-PC selection for the fetch stage.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   run             : fetch FSM is in RUN (PC frozen while booting)
//   pipeline_stop   : load-use stall, hold the PC
//   redirect        : EX-resolved taken branch/jump
//   redirect_pc     : redirect target (low two bits are ignored)
//   pc_q            : PC of the instruction currently returned by the ROM
//   pc_next         : address presented to the ROM this cycle
//   pc_plus4        : pc_q + 4
// ---------------------------------------------------------------------------
module pc_gen
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        pipeline_stop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_q,
    output logic [31:0] pc_next,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect beats stall; targets are forced word-aligned.
    always_comb begin
        pc_next = pc_q;
        if (run) begin
            if (redirect) begin
                pc_next = {redirect_pc[31:2], 2'b00};
            end else if (!pipeline_stop) begin
                pc_next = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// Fetch stage plus IF/ID pipeline register. Drives the synchronous-read
// instruction ROM, applies load-use stalls and EX redirects, and presents
// the fetched slot to ID. Empty and wrong-path slots carry pc4 with the
// discard bit set.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   pipeline_stop_i            : load-use stall from hazard unit
//   redirect_i, redirect_pc_i  : taken branch/jump resolved in EX + target
//   irom_addr_o                : ROM read address (ROM registers it)
//   irom_inst_i                : ROM data, one cycle after the address
//   id_inst_o, id_pc_o         : instruction and its PC for ID
//   id_pc4_o                   : PC+4, bit 31 set = discard
//   id_debug_wb_have_inst_o    : slot holds a real instruction
//   fetch_cnt_o                : real instructions loaded into IF/ID
//                                (only when IF_FETCH_CNT_EN is defined)
// Optional feature macro: IF_FETCH_CNT_EN
// ---------------------------------------------------------------------------
module if_id_stage
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipeline_stop_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] irom_addr_o,
    input  logic [31:0] irom_inst_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic        id_debug_wb_have_inst_o
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o
`endif
);

    fetch_state_e state_q;
    fetch_state_e state_next;
    logic [31:0]  pc_q;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    if_id_t       slot_q;
    if_id_t       slot_next;
    logic         load_real;
    logic         run;

    assign run = (state_q == RUN);

    pc_gen u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .pipeline_stop (pipeline_stop_i),
        .redirect      (redirect_i),
        .redirect_pc   (redirect_pc_i),
        .pc_q          (pc_q),
        .pc_next       (pc_next),
        .pc_plus4      (pc_plus4)
    );

    // The ROM registers the address, so the word it returns next cycle
    // belongs to whatever pc_q becomes at this edge.
    assign irom_addr_o = pc_next;

    // BOOT lasts exactly one cycle so the ROM can return the RESET_PC word.
    always_comb begin
        state_next = state_q;
        case (state_q)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_next;
        end
    end

    // Redirect squashes the slot even if a stall is asserted the same cycle.
    always_comb begin
        slot_next = slot_q;
        load_real = 1'b0;
        if (!run || redirect_i) begin
            slot_next = bubble_slot();
        end else if (!pipeline_stop_i) begin
            slot_next.inst      = irom_inst_i;
            slot_next.pc        = pc_q;
            slot_next.pc4       = pc_plus4;
            slot_next.have_inst = 1'b1;
            load_real           = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= bubble_slot();
        end else begin
            slot_q <= slot_next;
        end
    end

    // The instruction in ID during a redirect is wrong-path; flag it now so
    // ID/EX discards what it latches on this edge.
    always_comb begin
        id_pc4_o              = slot_q.pc4;
        id_pc4_o[DISCARD_BIT] = slot_q.pc4[DISCARD_BIT] | redirect_i;
    end

    assign id_inst_o               = slot_q.inst;
    assign id_pc_o                 = slot_q.pc;
    assign id_debug_wb_have_inst_o = slot_q.have_inst;

`ifdef IF_FETCH_CNT_EN
    // Counts only real instructions entering ID; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_o <= 32'd0;
        end else if (load_real) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end
`else
    logic unused_load_real;
    assign unused_load_real = load_real;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
// Self-checking bench for if_id_stage. A ROM model returns a word derived
// from the address one cycle later; a behavioural model tracks the fetch
// address, the ID slot and the fetch count.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

    localparam logic [31:0] B_PC4  = 32'hFFFF_FF00;
    localparam logic [31:0] B_PC   = 32'hFFFF_FEFC;
    localparam logic [31:0] B_INST = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        pipeline_stop_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] irom_addr_o;
    logic [31:0] irom_inst_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
    logic        id_debug_wb_have_inst_o;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    // Model state
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_id_pc;
    logic [31:0] m_pc4;
    bit          m_have;
    logic [31:0] m_cnt;

    if_id_stage dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .pipeline_stop_i         (pipeline_stop_i),
        .redirect_i              (redirect_i),
        .redirect_pc_i           (redirect_pc_i),
        .irom_addr_o             (irom_addr_o),
        .irom_inst_i             (irom_inst_i),
        .id_inst_o               (id_inst_o),
        .id_pc_o                 (id_pc_o),
        .id_pc4_o                (id_pc4_o),
        .id_debug_wb_have_inst_o (id_debug_wb_have_inst_o)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_cnt_o             (fetch_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Synchronous-read ROM
    always @(posedge clk) irom_inst_i <= rom_word(irom_addr_o);

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = 32'h0;
        m_inst  = B_INST;
        m_id_pc = B_PC;
        m_pc4   = B_PC4;
        m_have  = 1'b0;
        m_cnt   = 32'h0;
    endtask

    function automatic logic [31:0] model_fetch_addr();
        if (m_boot)          return m_pc;
        if (redirect_i)      return {redirect_pc_i[31:2], 2'b00};
        if (pipeline_stop_i) return m_pc;
        return m_pc + 32'd4;
    endfunction

    // Called right after a negedge; inputs settle 1 time unit later.
    task automatic set_in(input bit s, input bit r, input logic [31:0] t);
        pipeline_stop_i = s;
        redirect_i      = r;
        redirect_pc_i   = t;
        #1;
    endtask

    // One clock: move the model across the edge, then return on the negedge.
    task automatic advance();
        logic [31:0] nxt;
        nxt = model_fetch_addr();
        @(posedge clk);
        if (m_boot || redirect_i) begin
            m_inst = B_INST; m_id_pc = B_PC; m_pc4 = B_PC4; m_have = 1'b0;
        end else if (!pipeline_stop_i) begin
            m_inst = rom_word(m_pc); m_id_pc = m_pc; m_pc4 = m_pc + 32'd4;
            m_have = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        m_pc   = nxt;
        m_boot = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 32'h0);
        repeat (2) @(negedge clk);
        total++; if (id_inst_o !== B_INST) begin bad++; $display("[TB] FAIL reset_inst got=%h exp=%h", id_inst_o, B_INST); end
        total++; if (id_pc_o !== B_PC) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", id_pc_o, B_PC); end
        total++; if (id_pc4_o !== B_PC4) begin bad++; $display("[TB] FAIL reset_pc4 got=%h exp=%h", id_pc4_o, B_PC4); end
        total++; if (id_debug_wb_have_inst_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_have got=%b exp=0", id_debug_wb_have_inst_o); end
        total++; if (irom_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=0", irom_addr_o); end
`ifdef IF_FETCH_CNT_EN
        total++; if (fetch_cnt_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_cnt got=%h exp=0", fetch_cnt_o); end
`endif
        model_reset();
        rst_n = 1'b1;
        set_in(0, 0, 32'h0);
    endtask

    task automatic test_sequential();
        advance();
        total++; if (id_debug_wb_have_inst_o !== 1'b0 || id_pc4_o !== B_PC4) begin
            bad++; $display("[TB] FAIL boot_bubble got have=%b pc4=%h exp have=0 pc4=%h", id_debug_wb_have_inst_o, id_pc4_o, B_PC4);
        end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] p;
            p = 32'(k * 4);
            advance();
            total++; if (id_pc_o !== p || id_inst_o !== rom_word(p) || id_debug_wb_have_inst_o !== 1'b1 || id_pc4_o !== p + 32'd4) begin
                bad++; $display("[TB] FAIL seq_%0d got pc=%h inst=%h pc4=%h have=%b exp pc=%h inst=%h", k, id_pc_o, id_inst_o, id_pc4_o, id_debug_wb_have_inst_o, p, rom_word(p));
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 32'h0);
            total++; if (irom_addr_o !== 32'hC || id_pc_o !== 32'h8) begin
                bad++; $display("[TB] FAIL stall_%0d got addr=%h pc=%h exp addr=c pc=8", k, irom_addr_o, id_pc_o);
            end
            advance();
        end
        total++; if (id_pc_o !== 32'h8 || id_debug_wb_have_inst_o !== 1'b1) begin
            bad++; $display("[TB] FAIL stall_hold got pc=%h have=%b exp pc=8 have=1", id_pc_o, id_debug_wb_have_inst_o);
        end
        set_in(0, 0, 32'h0);
        total++; if (irom_addr_o !== 32'h10) begin bad++; $display("[TB] FAIL stall_release_addr got=%h exp=10", irom_addr_o); end
        advance();
        total++; if (id_pc_o !== 32'hC || id_inst_o !== rom_word(32'hC)) begin
            bad++; $display("[TB] FAIL stall_resume got pc=%h inst=%h exp pc=c inst=%h", id_pc_o, id_inst_o, rom_word(32'hC));
        end
`ifdef IF_FETCH_CNT_EN
        total++; if (fetch_cnt_o !== 32'd4) begin bad++; $display("[TB] FAIL stall_cnt got=%0d exp=4", fetch_cnt_o); end
`endif
    endtask

    task automatic test_redirect();
        int guard;
        guard = 0;
        while (id_pc_o !== 32'h10 && guard < 8) begin
            advance();
            guard++;
        end
        total++; if (id_pc_o !== 32'h10) begin bad++; $display("[TB] FAIL redir_reach got pc=%h exp=10", id_pc_o); end
        set_in(0, 1, 32'h100);
        total++; if (id_pc4_o !== 32'h8000_0014) begin bad++; $display("[TB] FAIL redir_discard got=%h exp=80000014", id_pc4_o); end
        total++; if (irom_addr_o !== 32'h100) begin bad++; $display("[TB] FAIL redir_addr got=%h exp=100", irom_addr_o); end
        advance();
        set_in(0, 0, 32'h0);
        total++; if (id_pc4_o !== B_PC4 || id_debug_wb_have_inst_o !== 1'b0 || id_pc_o !== B_PC || id_inst_o !== B_INST) begin
            bad++; $display("[TB] FAIL redir_bubble got pc=%h pc4=%h have=%b", id_pc_o, id_pc4_o, id_debug_wb_have_inst_o);
        end
        advance();
        total++; if (id_pc_o !== 32'h100 || id_inst_o !== rom_word(32'h100) || id_debug_wb_have_inst_o !== 1'b1) begin
            bad++; $display("[TB] FAIL redir_target got pc=%h inst=%h exp pc=100", id_pc_o, id_inst_o);
        end
    endtask

    task automatic test_redirect_stall();
        set_in(1, 1, 32'h40);
        total++; if (irom_addr_o !== 32'h40) begin bad++; $display("[TB] FAIL rs_addr got=%h exp=40", irom_addr_o); end
        advance();
        total++; if (id_debug_wb_have_inst_o !== 1'b0 || id_pc4_o !== B_PC4) begin
            bad++; $display("[TB] FAIL rs_bubble got have=%b pc4=%h", id_debug_wb_have_inst_o, id_pc4_o);
        end
        set_in(0, 0, 32'h0);
        advance();
        total++; if (id_pc_o !== 32'h40 || id_debug_wb_have_inst_o !== 1'b1) begin
            bad++; $display("[TB] FAIL rs_target got pc=%h have=%b exp pc=40", id_pc_o, id_debug_wb_have_inst_o);
        end
    endtask

    task automatic test_misaligned();
        set_in(0, 1, 32'h103);
        total++; if (irom_addr_o !== 32'h100) begin bad++; $display("[TB] FAIL misalign_addr got=%h exp=100", irom_addr_o); end
        advance();
        set_in(0, 0, 32'h0);
        advance();
        total++; if (id_pc_o !== 32'h100 || id_inst_o !== rom_word(32'h100)) begin
            bad++; $display("[TB] FAIL misalign_target got pc=%h inst=%h exp pc=100", id_pc_o, id_inst_o);
        end
    endtask

    task automatic test_back_to_back();
        set_in(0, 1, 32'h200);
        advance();
        set_in(0, 1, 32'h300);
        total++; if (id_pc4_o !== B_PC4 || irom_addr_o !== 32'h300) begin
            bad++; $display("[TB] FAIL b2b_mid got pc4=%h addr=%h exp pc4=%h addr=300", id_pc4_o, irom_addr_o, B_PC4);
        end
        advance();
        set_in(0, 0, 32'h0);
        total++; if (id_debug_wb_have_inst_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_bubble got have=%b exp=0", id_debug_wb_have_inst_o); end
        advance();
        total++; if (id_pc_o !== 32'h300 || id_inst_o !== rom_word(32'h300)) begin
            bad++; $display("[TB] FAIL b2b_target got pc=%h exp=300", id_pc_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit          s;
            bit          r;
            logic [31:0] t;
            logic [31:0] exp_pc4;
            s = ($urandom % 4) == 0;
            r = ($urandom % 8) == 0;
            t = $urandom_range(0, 32'h3FFF);
            set_in(s, r, t);
            exp_pc4 = m_pc4 | {r, 31'b0};
            total++; if (irom_addr_o !== model_fetch_addr() || id_pc4_o !== exp_pc4) begin
                bad++; $display("[TB] FAIL rand_comb_%0d got addr=%h pc4=%h exp addr=%h pc4=%h", i, irom_addr_o, id_pc4_o, model_fetch_addr(), exp_pc4);
            end
            advance();
            total++; if (id_inst_o !== m_inst || id_pc_o !== m_id_pc || id_debug_wb_have_inst_o !== m_have) begin
                bad++; $display("[TB] FAIL rand_slot_%0d got inst=%h pc=%h have=%b exp inst=%h pc=%h have=%b", i, id_inst_o, id_pc_o, id_debug_wb_have_inst_o, m_inst, m_id_pc, m_have);
            end
`ifdef IF_FETCH_CNT_EN
            total++; if (fetch_cnt_o !== m_cnt) begin bad++; $display("[TB] FAIL rand_cnt_%0d got=%0d exp=%0d", i, fetch_cnt_o, m_cnt); end
`endif
        end
        set_in(0, 0, 32'h0);
    endtask

    task automatic test_reset_midstream();
        repeat (3) advance();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (id_inst_o !== B_INST || id_pc_o !== B_PC || id_pc4_o !== B_PC4 || id_debug_wb_have_inst_o !== 1'b0 || irom_addr_o !== 32'h0) begin
            bad++; $display("[TB] FAIL midreset got inst=%h pc=%h pc4=%h have=%b addr=%h", id_inst_o, id_pc_o, id_pc4_o, id_debug_wb_have_inst_o, irom_addr_o);
        end
`ifdef IF_FETCH_CNT_EN
        total++; if (fetch_cnt_o !== 32'h0) begin bad++; $display("[TB] FAIL midreset_cnt got=%h exp=0", fetch_cnt_o); end
`endif
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        set_in(0, 0, 32'h0);
        advance();
        advance();
        total++; if (id_pc_o !== 32'h0 || id_inst_o !== rom_word(32'h0) || id_debug_wb_have_inst_o !== 1'b1) begin
            bad++; $display("[TB] FAIL midreset_restart got pc=%h inst=%h have=%b exp pc=0", id_pc_o, id_inst_o, id_debug_wb_have_inst_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
